// File: rtl/hex_operand_entry_if.sv
// rtl/hex_operand_entry_if.sv - operand valid/ready handshake between entry front end and consumer
interface hex_operand_entry_if #(
    parameter int N = 8
);
    logic [N-1:0] operand;
    logic         operand_valid;
    logic         operand_ready;

    modport master (
        output operand,
        output operand_valid,
        input  operand_ready
    );

    modport slave (
        input  operand,
        input  operand_valid,
        output operand_ready
    );
endinterface

// File: rtl/hex_operand_entry.sv
// rtl/hex_operand_entry.sv - hex digit keypad entry with debounced keys and operand handshake
module hex_operand_entry #(
    parameter int N          = 8,
    parameter int DEB_CYCLES = 500000,
    localparam int CW        = $clog2(N / 4 + 1)
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic [3:0]    digit_in,
    input  logic          enter_n,
    input  logic          commit_n,
    input  logic          clear_entry,
    output logic [N-1:0]  entry,
    output logic [CW-1:0] digit_cnt,
    hex_operand_entry_if.master op
);

    localparam int            DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DIGITS   = CW'(N / 4);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        HOLD
    } state_t;

    // Index 0 is the enter key, index 1 the commit key.
    logic [1:0]    raw_n;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [DW-1:0] dcnt [0:1];
    logic [1:0]    press;
    logic          enter_ev;
    logic          commit_ev;

    assign raw_n = {commit_n, enter_n};

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            deb_d   <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            sync1 <= ~raw_n;
            sync2 <= sync1;
            deb_d <= deb;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    dcnt[k] <= '0;
                end else if (dcnt[k] == DEB_LAST) begin
                    deb[k]  <= sync2[k];
                    dcnt[k] <= '0;
                end else begin
                    dcnt[k] <= dcnt[k] + 1'b1;
                end
            end
        end
    end

    assign press     = deb & ~deb_d;
    assign enter_ev  = press[0];
    assign commit_ev = press[1];

    state_t        state_q;
    state_t        state_d;
    logic [N-1:0]  entry_q;
    logic [N-1:0]  entry_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [N-1:0]  operand_q;
    logic [N-1:0]  operand_d;
    logic [N+3:0]  shifted;

    assign shifted = {entry_q, digit_in};

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q   <= IDLE;
            entry_q   <= '0;
            cnt_q     <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
        end
    end

    // Priority outside HOLD: clear, then commit (which swallows a same-cycle digit), then enter.
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        operand_d = operand_q;
        case (state_q)
            IDLE, ENTRY: begin
                if (clear_entry) begin
                    state_d = IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (commit_ev) begin
                    if (state_q == ENTRY) begin
                        operand_d = entry_q;
                        state_d   = HOLD;
                    end
                end else if (enter_ev && (cnt_q < DIGITS)) begin
                    entry_d = shifted[N-1:0];
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ENTRY;
                end
            end
            HOLD: begin
                if (op.operand_ready) begin
                    state_d = IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign entry            = entry_q;
    assign digit_cnt        = cnt_q;
    assign op.operand       = operand_q;
    assign op.operand_valid = (state_q == HOLD);

endmodule

// File: doc/hex_operand_entry.md
Name: hex_operand_entry

Overview:
- Operand-entry front end that builds an N-bit operand from hex digits keyed in on the board (SW digit + pushbuttons).
- Presents the operand to a downstream consumer, such as the add/sub accumulator, over a valid/ready handshake.
- Input-side counterpart of the accumulator's segment-decoder output path: raw keys and switches in, clean binary operand out.
- Includes key synchronisation, debouncing and press-edge detection; the top-level wrapper connects KEY/SW directly.

Parameters:
- N, 8, operand width in bits; must be a multiple of 4 and at least 4.
- DEB_CYCLES, 500000, consecutive stable cycles required before a debounced key level changes (use 4 in simulation).

Ports:
- clk  in  1  system clock, rising edge.
- aclr  in  1  asynchronous, active-high reset.
- digit_in  in  4  hex digit from switches; sampled when an enter event occurs.
- enter_n  in  1  raw pushbutton, active low; shifts digit_in into the entry.
- commit_n  in  1  raw pushbutton, active low; commits the entry as an operand.
- clear_entry  in  1  synchronous, active high; discards the partial entry.
- operand_ready  in  1  consumer accepts the operand.
- operand  out  N  committed operand; stable while operand_valid is high.
- operand_valid  out  1  operand offered to the consumer.
- entry  out  N  partial entry, for display echo.
- digit_cnt  out  clog2(N/4+1)  number of digits entered so far.

Behaviour:
- Reset (aclr=1, asynchronous):
  - operand, entry, digit_cnt and operand_valid = 0.
  - FSM = IDLE.
  - Synchronisers and debouncers = released (not pressed); debounce counters = 0.
- Key path, per key:
  - 2-flop synchroniser on the inverted raw input (pressed = 1).
  - Debounce counter clears whenever the synchronised level equals the debounced level; otherwise it increments.
  - When the counter reaches DEB_CYCLES-1, the debounced level flips and the counter clears.
  - Press event = one-cycle pulse on the debounced 0->1 transition. Releases generate no event.
  - Latency from raw press (held stable) to event pulse: 2 + DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES cycles produce no event.
- FSM states: IDLE (digit_cnt=0), ENTRY (1..N/4 digits), HOLD (operand_valid=1).
- IDLE:
  - enter event -> entry = {entry[N-5:0], digit_in}, digit_cnt=1, go to ENTRY.
  - commit event ignored.
- ENTRY:
  - enter event with digit_cnt < N/4 -> shift digit in, digit_cnt+1.
  - enter event with digit_cnt = N/4 -> ignored; entry unchanged, no wrap.
  - commit event -> next cycle: operand = entry (right-aligned, upper bits zero), operand_valid=1, go to HOLD.
- HOLD:
  - operand_valid stays high and operand stays stable until operand_ready=1 is sampled.
  - On that edge: operand_valid=0, entry=0, digit_cnt=0, go to IDLE. operand keeps its last value.
  - enter and commit events are dropped; they are not queued.
- clear_entry:
  - In IDLE or ENTRY: entry=0, digit_cnt=0, go to IDLE.
  - In HOLD: ignored.
- Simultaneous events:
  - commit and enter in the same cycle: commit wins, digit discarded.
  - clear_entry with any event in the same cycle: clear wins.
- operand_ready outside HOLD has no effect.
- aclr mid-debounce or in HOLD: immediate return to reset values; the offered operand is lost.

Test Plan (DEB_CYCLES=4, N=8):
- Press enter_n with digit_in=4'hA, then again with 4'h5, then commit_n -> entry=8'hA5, digit_cnt=2; operand_valid rises with operand=8'hA5; with operand_ready=0 held 20 cycles, valid and operand stay unchanged; one cycle of ready -> valid=0, entry=0, digit_cnt=0.
- Hold enter_n low for 3 cycles (glitch) -> no event; entry=0, digit_cnt=0. Hold it low for 10 cycles -> exactly one event, first event 6 cycles after the press.
- Three enter presses with digits 1, 2, 3 -> entry=8'h12, digit_cnt=2; third digit ignored.
- One digit 7, then commit -> operand=8'h07. Commit in IDLE -> operand_valid stays 0.
- In HOLD, press enter (digit F), then ready -> entry=0 after accept; the F is not captured. clear_entry in HOLD -> no change.
- Assert aclr asynchronously mid-HOLD -> operand_valid and all outputs 0 immediately; new entry works after release.
